uart_tx_param: RTL and testbench

// - Parametrised next-generation UART transmitter: configurable data width, oversample ratio,
//   1/2 stop bits, optional parity, plus an input FIFO so producers can push while a frame is in flight.
// - Sits between the byte-stream producer (valid/ready) and the serial pin; shares baud_tick with uart_rx.

---
 rtl/uart_tx_param.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an input FIFO, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK line state.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        baud_tick,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                        break_req,
`endif
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IW = $clog2(DATA_BITS);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_on, par_bit, stop_long, stop_second;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count_next;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, brk, bit_end, last_stop;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    assign head       = mem[rd_ptr];
    assign push       = in_valid && in_ready;
    assign bit_end    = (tick_cnt == TW'(OVERSAMPLE - 1));
    assign last_stop  = (state == STOP) && bit_end && (!stop_long || stop_second);
    // Pop on the first idle tick, or on the final stop tick so the next start bit follows with no gap.
    assign pop        = baud_tick && (fifo_count != '0) &&
                        (((state == IDLE) && !brk) || last_stop);
    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign busy       = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_next;
            in_ready   <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_on      <= 1'b0;
            par_bit     <= 1'b0;
            stop_long   <= 1'b0;
            stop_second <= 1'b0;
        end else if (pop) begin
            // Frame configuration is captured here and held for the whole frame.
            state     <= START;
            tx        <= 1'b0;
            tick_cnt  <= '0;
            shift     <= head;
            par_on    <= parity_en;
            par_bit   <= (^head) ^ parity_odd;
            stop_long <= stop2;
        end else if (baud_tick) begin
            case (state)
`ifdef UART_TX_BREAK_EN
                IDLE: begin
                    if (brk) begin
                        state <= BREAK;
                        tx    <= 1'b0;
                    end
                end
                BREAK: begin
                    if (!brk) begin
                        state       <= STOP;
                        tx          <= 1'b1;
                        tick_cnt    <= '0;
                        stop_long   <= 1'b0;
                        stop_second <= 1'b0;
                    end
                end
`endif
                START, DATA, PARITY, STOP: begin
                    if (!bit_end) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end else begin
                        tick_cnt <= '0;
                        case (state)
                            START: begin
                                state   <= DATA;
                                tx      <= shift[0];
                                bit_idx <= '0;
                            end
                            DATA: begin
                                if (bit_idx == IW'(DATA_BITS - 1)) begin
                                    bit_idx <= '0;
                                    if (par_on) begin
                                        state <= PARITY;
                                        tx    <= par_bit;
                                    end else begin
                                        state       <= STOP;
                                        tx          <= 1'b1;
                                        stop_second <= 1'b0;
                                    end
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                    tx      <= shift[1];
                                    shift   <= shift >> 1;
                                end
                            end
                            PARITY: begin
                                state       <= STOP;
                                tx          <= 1'b1;
                                stop_second <= 1'b0;
                            end
                            STOP: begin
                                if (stop_long && !stop_second) stop_second <= 1'b1;
                                else                           state       <= IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: two instances (8b/x16 and 7b/x4) against a per-tick line model.
module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, baud_tick = 1'b0, in_valid = 1'b0;
    logic [7:0] din = '0;
    logic       parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0, break_req = 1'b0;

    logic       rdy0, tx0, busy0, rdy1, tx1, busy1;
    logic [2:0] cnt0, cnt1;

    uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(din), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx0), .busy(busy0), .fifo_count(cnt0));

    uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(4), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(din[6:0]), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx1), .busy(busy1), .fifo_count(cnt1));

    int npass = 0, ntotal = 0;
    int DBv[2] = '{8, 7};
    int OSv[2] = '{16, 4};

    // Model: queued words, and the frame currently on the line as a bit vector walked tick by tick.
    logic [7:0]  mf[2][4];
    int          mhead[2], mcnt[2];
    logic [15:0] fvec[2];
    int          flen[2], fpos[2];
    bit          act[2], brk[2], acc0;
    logic        etx[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    function automatic void build(input int i, input logic [7:0] d,
                                  output logic [15:0] v, output int len);
        int   nb;
        logic par;
        v    = '1;
        v[0] = 1'b0;
        par  = parity_odd;
        for (int k = 0; k < DBv[i]; k++) begin
            v[1+k] = d[k];
            par    = par ^ d[k];
        end
        nb = 2 + DBv[i] + int'(stop2);
        if (parity_en) begin
            v[1+DBv[i]] = par;
            nb++;
        end
        len = nb * OSv[i];
    endfunction

    task automatic model_edge(input bit tick);
        bit acc;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mhead[i] = 0; mcnt[i] = 0; act[i] = 0; brk[i] = 0;
                flen[i] = 0; fpos[i] = 0; etx[i] = 1'b1;
                if (i == 0) acc0 = 0;
                continue;
            end
            acc = in_valid && (mcnt[i] < 4);
            if (i == 0) acc0 = acc;
            if (tick) begin
                if (brk[i]) begin
                    if (break_req) etx[i] = 1'b0;
                    else begin
                        brk[i] = 0; fvec[i] = '1; flen[i] = OSv[i]; fpos[i] = 1; etx[i] = 1'b1;
                    end
                end else if (fpos[i] >= flen[i]) begin
                    if (!act[i] && break_req) begin
                        brk[i] = 1; act[i] = 1; etx[i] = 1'b0;
                    end else if (mcnt[i] > 0) begin
                        build(i, mf[i][mhead[i]], fvec[i], flen[i]);
                        mhead[i] = (mhead[i] + 1) % 4;
                        mcnt[i]--;
                        fpos[i] = 1; act[i] = 1; etx[i] = fvec[i][0];
                    end else begin
                        act[i] = 0; etx[i] = 1'b1;
                    end
                end else begin
                    etx[i] = fvec[i][fpos[i] / OSv[i]];
                    fpos[i]++;
                end
            end
            if (acc) begin
                mf[i][(mhead[i] + mcnt[i]) % 4] = (i == 0) ? din : (din & 8'h7F);
                mcnt[i]++;
            end
        end
    endtask

    task automatic step(input bit tick);
        baud_tick = tick;
        @(posedge clk);
        model_edge(tick);
        #1;
        chk("tx0",    32'(tx0),   32'(etx[0]));
        chk("busy0",  32'(busy0), 32'(act[0] || brk[0] || mcnt[0] > 0));
        chk("ready0", 32'(rdy0),  32'(mcnt[0] < 4));
        chk("count0", 32'(cnt0),  32'(mcnt[0]));
        chk("tx1",    32'(tx1),   32'(etx[1]));
        chk("busy1",  32'(busy1), 32'(act[1] || brk[1] || mcnt[1] > 0));
        chk("ready1", 32'(rdy1),  32'(mcnt[1] < 4));
        chk("count1", 32'(cnt1),  32'(mcnt[1]));
        baud_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    task automatic push1(input logic [7:0] d);
        din = d; in_valid = 1'b1;
        step(1'b0);
        in_valid = 1'b0;
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        step(1'b0); step(1'b0);
        reset = 1'b0;
        step(1'b0);

        push1(8'hA5);
        ticks(180);

        parity_en = 1'b1; parity_odd = 1'b0; push1(8'h07); ticks(190);
        parity_odd = 1'b1;                   push1(8'h07); ticks(190);
        parity_odd = 1'b0;                   push1(8'h00); ticks(190);
        parity_en = 1'b0;

        // Fill the FIFO during a frame; the 5th word is held until the first pop frees a slot.
        push1(8'h11);
        ticks(5);
        for (int k = 0; k < 4; k++) begin
            din = 8'h20 + 8'(k); in_valid = 1'b1;
            step(1'b0);
        end
        din = 8'h5E; in_valid = 1'b1;
        waited = 0;
        step(1'b0);
        while (!acc0 && waited < 4000) begin
            step(waited % 2 == 0);
            waited++;
        end
        chk("hold_timeout", 32'(acc0), 32'd1);
        in_valid = 1'b0;
        ticks(900);

        stop2 = 1'b1;
        push1(8'h55);
        ticks(200);
        push1(8'hC3); push1(8'h3A);
        ticks(400);
        stop2 = 1'b0;

        // Abort mid-frame with words still queued, then a clean frame.
        push1(8'h96); push1(8'h69); push1(8'hF0);
        ticks(70);
        reset = 1'b1; step(1'b1);
        reset = 1'b0; step(1'b0);
        push1(8'h81);
        ticks(200);

`ifdef UART_TX_BREAK_EN
        break_req = 1'b1;
        push1(8'h3C);
        ticks(50);
        break_req = 1'b0;
        ticks(200);
        push1(8'hE7);
        ticks(40);
        break_req = 1'b1;
        ticks(20);
        break_req = 1'b0;
        ticks(200);
`endif

        for (int k = 0; k < 4000; k++) begin
            din        = 8'($urandom);
            in_valid   = ($urandom_range(0, 7) == 0);
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            stop2      = 1'($urandom);
`ifdef UART_TX_BREAK_EN
            if ($urandom_range(0, 99) == 0) break_req = ~break_req;
`endif
            step($urandom_range(0, 2) == 0);
        end
        in_valid = 1'b0; break_req = 1'b0;
        ticks(600);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
